// File: rtl/ld_mem_port_pkg.sv
// Local types for ld_mem_port: tag-pipe entry and FSM states.
package ld_mem_port_pkg;

    typedef struct packed {
        logic       v;
        logic [1:0] mode;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/pkg_en.sv
// Token types shared by the load/store network.
// Forward tokens carry data; backward tokens carry nack.
package pkg_en;

    localparam int WIDTH_DATA = 8;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic [1:0]            c;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic       n;
        logic [1:0] c;
    } BTk_t;

endpackage

// File: rtl/pkg_mem.sv
// Memory-side defaults and access-mode bit positions.
package pkg_mem;

    localparam int MEM_LATENCY_DEF = 2;
    localparam int DEPTH_RET_DEF   = 8;

    localparam int MODE_FIRST = 0;
    localparam int MODE_LAST  = 1;

endpackage

// File: rtl/RingBuffCTRL.sv
// Ring-buffer bookkeeping: pointers, occupancy, full/empty.
module RingBuffCTRL #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int CW = AW + 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/ld_mem_tagpipe.sv
// Fixed-latency tag shift register aligned with memory read data.
module ld_mem_tagpipe
    import ld_mem_port_pkg::*;
#(
    parameter int LAT = 2,
    parameter int IFW = $clog2(LAT + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_v,
    input  logic [1:0]     in_mode,
    output logic           tail_v,
    output logic [1:0]     tail_mode,
    output logic [IFW-1:0] inflight
);

    tag_t pipe [LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{v: in_v, mode: in_mode};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail_v    = pipe[LAT-1].v;
    assign tail_mode = pipe[LAT-1].mode;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + IFW'(pipe[i].v);
        end
    end

endmodule

// File: rtl/ld_mem_port.sv
// Load port: issues reads, tags returns, buffers words with nack.
// LD_MEM_PORT_OUTREG_EN registers the returned token.
module ld_mem_port
    import pkg_en::*;
    import pkg_mem::*;
    import ld_mem_port_pkg::*;
#(
    parameter int WIDTH_ADDR  = 8,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int DEPTH_RET   = DEPTH_RET_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Req,
    input  logic [1:0]            I_AccessMode,
    input  logic [WIDTH_ADDR-1:0] I_Address,
    output logic                  O_Mem_Re,
    output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
    input  logic [WIDTH_DATA-1:0] I_Mem_Data,
    output FTk_t                  O_Ld_FTk,
    input  BTk_t                  I_Ld_BTk,
    output BTk_t                  O_Ld_BTk,
    output logic                  O_Busy
);

    localparam int AW  = $clog2(DEPTH_RET);
    localparam int CW  = AW + 1;
    localparam int IFW = $clog2(MEM_LATENCY + 1);
    localparam int SW  = AW + 2;

    logic           accept;
    logic           nack;
    logic           tail_v;
    logic [1:0]     tail_mode;
    logic [IFW-1:0] inflight;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           out_v;
    logic           out_v_nxt;
    logic [SW-1:0]  occ;
    FTk_t           ret_mem [DEPTH_RET];
    FTk_t           head;
    state_t         state;
    logic           unused_btk;

    assign unused_btk = ^I_Ld_BTk.c;

    assign accept     = I_Req & ~nack;
    assign O_Mem_Re   = accept;
    assign O_Mem_Addr = I_Address;

    ld_mem_tagpipe #(
        .LAT (MEM_LATENCY),
        .IFW (IFW)
    ) u_tagpipe (
        .clock     (clock),
        .reset     (reset),
        .in_v      (accept),
        .in_mode   (I_AccessMode),
        .tail_v    (tail_v),
        .tail_mode (tail_mode),
        .inflight  (inflight)
    );

    assign push = tail_v;

    RingBuffCTRL #(
        .DEPTH (DEPTH_RET),
        .AW    (AW)
    ) u_ring (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clock) begin
        if (push) begin
            ret_mem[wr_ptr] <= '{
                v: 1'b1,
                a: tail_mode[MODE_FIRST],
                r: tail_mode[MODE_LAST],
                c: 2'b00,
                d: I_Mem_Data
            };
        end
    end

    assign head = ret_mem[rd_ptr];

`ifdef LD_MEM_PORT_OUTREG_EN
    FTk_t out_q;
    logic load;

    assign load = ~empty & (~out_q.v | ~I_Ld_BTk.n);
    assign pop  = load;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else if (load) begin
            out_q <= head;
        end else if (out_q.v && !I_Ld_BTk.n) begin
            out_q <= '0;
        end
    end

    assign O_Ld_FTk  = out_q;
    assign out_v     = out_q.v;
    assign out_v_nxt = load | (out_q.v & I_Ld_BTk.n);
`else
    assign pop       = ~empty & ~I_Ld_BTk.n;
    assign O_Ld_FTk  = empty ? '0 : head;
    assign out_v     = 1'b0;
    assign out_v_nxt = 1'b0;
`endif

    // Everything accepted but not yet handed over reserves an entry.
    assign occ  = SW'(count) + SW'(inflight) + SW'(out_v);
    assign nack = occ >= SW'(DEPTH_RET);

    always_comb begin
        O_Ld_BTk   = '0;
        O_Ld_BTk.n = nack;
    end

    logic [CW-1:0]  count_nxt;
    logic [IFW-1:0] inflight_nxt;
    logic           inflight_zero;
    logic           held_zero;

    assign count_nxt     = count + CW'(push) - CW'(pop);
    assign inflight_nxt  = inflight + IFW'(accept) - IFW'(tail_v);
    assign inflight_zero = inflight_nxt == '0;
    assign held_zero     = (count_nxt == '0) && !out_v_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (!accept && inflight_zero) begin
                        state <= held_zero ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (accept)         state <= S_ACTIVE;
                    else if (held_zero) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign O_Busy = state != S_IDLE;

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset) !(push && full)
    ) else $fatal(1, "ld_mem_port: return buffer overflow");

endmodule

// File: tb/tb_ld_mem_port.sv
// Randomized scoreboard bench for ld_mem_port.
module tb_ld_mem_port;
    import pkg_en::*;

    localparam int L = 2;
    localparam int D = 8;
`ifdef LD_MEM_PORT_OUTREG_EN
    localparam int LAT_EXP = L + 2;
`else
    localparam int LAT_EXP = L + 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       I_Req = 1'b0;
    logic [1:0] I_AccessMode = '0;
    logic [7:0] I_Address = '0;
    logic       O_Mem_Re;
    logic [7:0] O_Mem_Addr;
    logic [7:0] I_Mem_Data = '0;
    FTk_t       O_Ld_FTk;
    BTk_t       I_Ld_BTk = '0;
    BTk_t       O_Ld_BTk;
    logic       O_Busy;

    ld_mem_port #(
        .WIDTH_ADDR  (8),
        .MEM_LATENCY (L),
        .DEPTH_RET   (D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req        (I_Req),
        .I_AccessMode (I_AccessMode),
        .I_Address    (I_Address),
        .O_Mem_Re     (O_Mem_Re),
        .O_Mem_Addr   (O_Mem_Addr),
        .I_Mem_Data   (I_Mem_Data),
        .O_Ld_FTk     (O_Ld_FTk),
        .I_Ld_BTk     (I_Ld_BTk),
        .O_Ld_BTk     (O_Ld_BTk),
        .O_Busy       (O_Busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       a;
        logic       r;
        logic [7:0] d;
        int         t;
        bit         exact;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] mem_model [256];
    int         vec  = 0;
    int         miss = 0;
    int         cyc  = 0;
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    bit         seen = 0;
    bit         pend = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Memory: returns mem_model[addr] L cycles after a read enable.
    logic       re_p [L];
    logic [7:0] ad_p [L];
    initial begin
        logic       cur_re;
        logic [7:0] cur_ad;
        for (int i = 0; i < L; i++) begin
            re_p[i] = 1'b0;
            ad_p[i] = '0;
        end
        forever begin
            @(negedge clock);
            cur_re = O_Mem_Re;
            cur_ad = O_Mem_Addr;
            @(posedge clock);
            for (int i = L - 1; i > 0; i--) begin
                re_p[i] = re_p[i-1];
                ad_p[i] = ad_p[i-1];
            end
            re_p[0] = cur_re;
            ad_p[0] = cur_ad;
            #1;
            I_Mem_Data = re_p[L-1] ? mem_model[ad_p[L-1]]
                                   : 8'($urandom);
        end
    end

    // Monitor: model outstanding words, check every output each cycle.
    initial forever begin
        int   out;
        exp_t e;
        @(negedge clock);
        if (reset) begin
            exp_q.delete();
            acc_cnt = 0;
            pop_cnt = 0;
            seen = 0;
        end else begin
            out = acc_cnt - pop_cnt;
            chk("nack", 32'(O_Ld_BTk.n), 32'(out >= D));
            chk("btk_pad", 32'(O_Ld_BTk.c), 0);
            chk("busy", 32'(O_Busy), 32'(out != 0));
            chk("mem_re", 32'(O_Mem_Re), 32'(I_Req && out < D));
            if (I_Req) chk("mem_addr", 32'(O_Mem_Addr), 32'(I_Address));
            if (O_Ld_FTk.v) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_tok", 32'(O_Ld_FTk.v), 0);
                end else begin
                    e = exp_q[0];
                    chk("tok_a", 32'(O_Ld_FTk.a), 32'(e.a));
                    chk("tok_r", 32'(O_Ld_FTk.r), 32'(e.r));
                    chk("tok_d", 32'(O_Ld_FTk.d), 32'(e.d));
                    chk("tok_c", 32'(O_Ld_FTk.c), 0);
                    if (!seen) begin
                        seen = 1;
                        if (e.exact) chk("latency", 32'(cyc - e.t), LAT_EXP);
                    end
                    if (!I_Ld_BTk.n) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                        seen = 0;
                    end
                end
            end else begin
                chk("idle_tok", 32'(O_Ld_FTk), 0);
            end
            if (I_Req && out < D) begin
                e.a = I_AccessMode[0];
                e.r = I_AccessMode[1];
                e.d = mem_model[I_Address];
                e.t = cyc;
                e.exact = (out == 0);
                exp_q.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [1:0] m);
        int k = 0;
        I_Req = 1'b1;
        I_Address = a;
        I_AccessMode = m;
        forever begin
            @(negedge clock);
            if (!O_Ld_BTk.n) break;
            k++;
            if (k > 200) begin
                chk("send_timeout", 32'(O_Ld_BTk.n), 0);
                break;
            end
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        I_Req = 1'b0;
    endtask

    task automatic run(input int n, input int preq, input int pnack);
        for (int i = 0; i < n; i++) begin
            if (!pend && int'($urandom_range(99)) < preq) begin
                pend = 1;
                I_Address = 8'($urandom);
                I_AccessMode = 2'($urandom);
            end
            I_Req = pend;
            I_Ld_BTk.n = int'($urandom_range(99)) < pnack;
            @(negedge clock);
            if (pend && !O_Ld_BTk.n) pend = 0;
            @(posedge clock);
            #1;
        end
        pend = 0;
        I_Req = 1'b0;
    endtask

    task automatic wait_idle();
        I_Req = 1'b0;
        I_Ld_BTk.n = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!O_Busy) break;
        end
        chk("idle_timeout", 32'(O_Busy), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        mem_model[8'h10] = 8'hA5;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        send(8'h10, 2'b11);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            send(8'(i), (i == 0) ? 2'b01 : (i == 7) ? 2'b10 : 2'b00);
        end
        wait_idle();

        a0 = acc_cnt;
        run(20, 100, 100);
        chk("stall_accepts", 32'(acc_cnt - a0), D);
        chk("stall_nack", 32'(O_Ld_BTk.n), 1);
        run(20, 0, 0);
        wait_idle();

        run(3000, 70, 40);
        wait_idle();

        I_Ld_BTk.n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            I_Req = 1'b1;
            I_Address = 8'(8'h40 + i);
            I_AccessMode = 2'($urandom);
            @(posedge clock);
            #1;
        end
        I_Req = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        I_Ld_BTk.n = 1'b0;
        #4;
        chk("rst_tok", 32'(O_Ld_FTk), 0);
        chk("rst_busy", 32'(O_Busy), 0);
        chk("rst_nack", 32'(O_Ld_BTk.n), 0);
        @(posedge clock);
        #1;
        run(15, 0, 0);
        wait_idle();

        run(600, 90, 20);
        wait_idle();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

endmodule
